// File: rtl/circle_pkg.sv
// Shared types for the parametrised circle rasteriser: FSM states, octant and span-row indices.
package circle_pkg;

    typedef enum logic [2:0] {
        CIRCLE_IDLE,
        CIRCLE_CLEAR,
        CIRCLE_INIT,
        CIRCLE_PLOT,
        CIRCLE_SPAN,
        CIRCLE_STEP,
        CIRCLE_DONE
    } circle_state_t;

    typedef logic [2:0] octant_t;
    typedef logic [1:0] span_row_t;

    localparam octant_t   OCT_LAST = 3'd7;
    localparam span_row_t ROW_LAST = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/circle_clip.sv
// Screen clipping: a signed pixel position becomes an in-bounds flag plus truncated unsigned x/y.
module circle_clip #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int CW       = 10
) (
    input  logic signed [CW-1:0] px,
    input  logic signed [CW-1:0] py,
    output logic                 in_bounds,
    output logic [X_W-1:0]       x,
    output logic [Y_W-1:0]       y
);

    localparam logic signed [CW-1:0] W_LIM = CW'(SCREEN_W);
    localparam logic signed [CW-1:0] H_LIM = CW'(SCREEN_H);

    assign in_bounds = !px[CW-1] && (px < W_LIM) && !py[CW-1] && (py < H_LIM);
    assign x         = px[X_W-1:0];
    assign y         = py[Y_W-1:0];

endmodule

// File: rtl/circle_engine_param.sv
// Midpoint circle rasteriser with optional screen clear, filled-disc mode and signed clipping.
// All plot outputs are registered from the current state, so they trail the state by one cycle.
module circle_engine_param
    import circle_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [X_W-1:0]      centre_x,
    input  logic [Y_W-1:0]      centre_y,
    input  logic [R_W-1:0]      radius,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                fill,
    input  logic                clear_first,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam int CW = max_int(max_int(X_W, R_W), Y_W) + 2;
    localparam int KW = R_W + 2;
    localparam logic [X_W-1:0]       CLR_X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0]       CLR_Y_LAST = Y_W'(SCREEN_H - 1);
    localparam logic signed [CW-1:0] ONE_C      = CW'(1);
    localparam logic signed [KW-1:0] ONE_K      = KW'(1);

    circle_state_t state, next_state;

    logic [X_W-1:0]       cx, clr_x, clip_x;
    logic [Y_W-1:0]       cy, clr_y, clip_y;
    logic [R_W-1:0]       rad;
    logic [COLOUR_W-1:0]  col;
    logic                 fill_mode;
    logic signed [CW-1:0] cx_s, cy_s, ox, oy, off, half, px, py, ox_next, oy_next;
    logic signed [KW-1:0] crit, crit_next;
    octant_t              oct;
    span_row_t            row;
    logic                 emit, clearing, span_row_end, in_bounds, crit_pos;

    assign cx_s         = $signed({{(CW-X_W){1'b0}}, cx});
    assign cy_s         = $signed({{(CW-Y_W){1'b0}}, cy});
    assign half         = row[1] ? oy : ox;
    assign span_row_end = (off == (half <<< 1));
    assign crit_pos     = !crit[KW-1] && (crit != {KW{1'b0}});

    // Midpoint decision step; both branches use the already-incremented oy.
    always_comb begin
        oy_next   = oy + ONE_C;
        ox_next   = ox;
        crit_next = crit;
        if (crit_pos) begin
            ox_next   = ox - ONE_C;
            crit_next = crit + KW'(((oy_next - (ox - ONE_C)) <<< 1) + ONE_C);
        end else begin
            crit_next = crit + KW'((oy_next <<< 1) + ONE_C);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CIRCLE_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the pixel position offered this cycle.
    always_comb begin
        next_state = state;
        emit       = 1'b0;
        clearing   = 1'b0;
        px         = {CW{1'b0}};
        py         = {CW{1'b0}};
        case (state)
            CIRCLE_IDLE: begin
                if (start) begin
                    next_state = clear_first ? CIRCLE_CLEAR : CIRCLE_INIT;
                end else begin
                    next_state = CIRCLE_IDLE;
                end
            end
            CIRCLE_CLEAR: begin
                emit     = 1'b1;
                clearing = 1'b1;
                px       = $signed({{(CW-X_W){1'b0}}, clr_x});
                py       = $signed({{(CW-Y_W){1'b0}}, clr_y});
                if ((clr_x == CLR_X_LAST) && (clr_y == CLR_Y_LAST)) begin
                    next_state = CIRCLE_INIT;
                end else begin
                    next_state = CIRCLE_CLEAR;
                end
            end
            CIRCLE_INIT: begin
                next_state = fill_mode ? CIRCLE_SPAN : CIRCLE_PLOT;
            end
            CIRCLE_PLOT: begin
                emit = 1'b1;
                case (oct)
                    3'd0:    begin px = cx_s + ox; py = cy_s + oy; end
                    3'd1:    begin px = cx_s + oy; py = cy_s + ox; end
                    3'd2:    begin px = cx_s - ox; py = cy_s + oy; end
                    3'd3:    begin px = cx_s - oy; py = cy_s + ox; end
                    3'd4:    begin px = cx_s - ox; py = cy_s - oy; end
                    3'd5:    begin px = cx_s - oy; py = cy_s - ox; end
                    3'd6:    begin px = cx_s + ox; py = cy_s - oy; end
                    default: begin px = cx_s + oy; py = cy_s - ox; end
                endcase
                next_state = (oct == OCT_LAST) ? CIRCLE_STEP : CIRCLE_PLOT;
            end
            CIRCLE_SPAN: begin
                emit = 1'b1;
                px   = cx_s - half + off;
                case (row)
                    2'd0:    py = cy_s + oy;
                    2'd1:    py = cy_s - oy;
                    2'd2:    py = cy_s + ox;
                    default: py = cy_s - ox;
                endcase
                if (span_row_end && (row == ROW_LAST)) begin
                    next_state = CIRCLE_STEP;
                end else begin
                    next_state = CIRCLE_SPAN;
                end
            end
            CIRCLE_STEP: begin
                if (oy_next <= ox_next) begin
                    next_state = fill_mode ? CIRCLE_SPAN : CIRCLE_PLOT;
                end else begin
                    next_state = CIRCLE_DONE;
                end
            end
            CIRCLE_DONE: begin
                next_state = start ? CIRCLE_DONE : CIRCLE_IDLE;
            end
            default: begin
                next_state = CIRCLE_IDLE;
            end
        endcase
    end

    // Request latch, clear scan counters and midpoint iteration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx <= {X_W{1'b0}}; cy <= {Y_W{1'b0}}; rad <= {R_W{1'b0}};
            col <= {COLOUR_W{1'b0}}; fill_mode <= 1'b0;
            clr_x <= {X_W{1'b0}}; clr_y <= {Y_W{1'b0}};
            ox <= {CW{1'b0}}; oy <= {CW{1'b0}}; off <= {CW{1'b0}};
            crit <= {KW{1'b0}}; oct <= 3'd0; row <= 2'd0;
        end else begin
            case (state)
                CIRCLE_IDLE: begin
                    if (start) begin
                        cx <= centre_x; cy <= centre_y; rad <= radius;
                        col <= colour; fill_mode <= fill;
                        clr_x <= {X_W{1'b0}}; clr_y <= {Y_W{1'b0}};
                    end
                end
                CIRCLE_CLEAR: begin
                    if (clr_y == CLR_Y_LAST) begin
                        clr_y <= {Y_W{1'b0}};
                        clr_x <= clr_x + {{(X_W-1){1'b0}}, 1'b1};
                    end else begin
                        clr_y <= clr_y + {{(Y_W-1){1'b0}}, 1'b1};
                    end
                end
                CIRCLE_INIT: begin
                    ox   <= $signed({{(CW-R_W){1'b0}}, rad});
                    oy   <= {CW{1'b0}};
                    crit <= ONE_K - $signed({2'b00, rad});
                    oct  <= 3'd0; row <= 2'd0; off <= {CW{1'b0}};
                end
                CIRCLE_PLOT: begin
                    oct <= oct + 3'd1;
                end
                CIRCLE_SPAN: begin
                    if (span_row_end) begin
                        off <= {CW{1'b0}};
                        row <= row + 2'd1;
                    end else begin
                        off <= off + ONE_C;
                    end
                end
                CIRCLE_STEP: begin
                    ox <= ox_next; oy <= oy_next; crit <= crit_next;
                    oct <= 3'd0; row <= 2'd0; off <= {CW{1'b0}};
                end
                default: begin
                    oct <= oct;
                end
            endcase
        end
    end

    circle_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .X_W      (X_W),
        .Y_W      (Y_W),
        .CW       (CW)
    ) u_clip (
        .px        (px),
        .py        (py),
        .in_bounds (in_bounds),
        .x         (clip_x),
        .y         (clip_y)
    );

    // Registered plot interface; done falls on the first edge that sees start low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done       <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= {X_W{1'b0}};
            vga_y      <= {Y_W{1'b0}};
            vga_colour <= {COLOUR_W{1'b0}};
        end else begin
            done       <= (state == CIRCLE_DONE) && !(done && !start);
            vga_plot   <= emit && in_bounds;
            vga_x      <= clip_x;
            vga_y      <= clip_y;
            vga_colour <= clearing ? {COLOUR_W{1'b0}} : col;
        end
    end

endmodule
